// File: rtl/pc_redirect_pkg.sv
// rtl/pc_redirect_pkg.sv - shared types and branch func3 encodings for the PC redirect unit
package pc_redirect_pkg;

  typedef enum logic [1:0] {
    BR_NONE   = 2'd0,
    BR_BRANCH = 2'd1,
    BR_JAL    = 2'd2,
    BR_JALR   = 2'd3
  } br_type_t;

  typedef enum logic {
    ST_SEQ        = 1'b0,
    ST_REDIR_WAIT = 1'b1
  } state_t;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

endpackage

// File: rtl/pc_redirect_unit_branch_cond_gen.sv
// rtl/pc_redirect_unit_branch_cond_gen.sv - conditional branch compare on forwarded operands
module branch_cond_gen
  import pc_redirect_pkg::*;
(
  input  logic [31:0] RS1,
  input  logic [31:0] RS2,
  input  logic [2:0]  EX_FUNC3,
  output logic        cond
);

  // Func3 selects the comparison; the two reserved encodings never branch.
  always_comb begin
    cond = 1'b0;
    case (EX_FUNC3)
      BEQ:     cond = (RS1 == RS2);
      BNE:     cond = (RS1 != RS2);
      BLT:     cond = ($signed(RS1) <  $signed(RS2));
      BGE:     cond = ($signed(RS1) >= $signed(RS2));
      BLTU:    cond = (RS1 <  RS2);
      BGEU:    cond = (RS1 >= RS2);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - fetch PC sequencing with EX-stage control transfer redirect
module pc_redirect_unit
  import pc_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EX_VALID,
  input  logic [1:0]  EX_BR_TYPE,
  input  logic [2:0]  EX_FUNC3,
  input  logic [31:0] RS1,
  input  logic [31:0] RS2,
  input  logic [31:0] JAL,
  input  logic [31:0] JALR,
  input  logic [31:0] BRANCH,
  input  logic        STALL,
  input  logic        IMEM_READY,
  output logic [31:0] PC_OUT,
  output logic [31:0] PC_PLUS4,
  output logic        FETCH_VALID,
  output logic        BR_TAKEN,
  output logic        FLUSH,
  output logic        REDIRECT_PENDING,
  output logic        MISALIGN
);

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] pending_q;
  br_type_t    br_type;
  logic        cond;
  logic        in_seq;
  logic        taken;
  logic        misaligned;
  logic        redirect;
  logic [31:0] target;

  assign br_type = br_type_t'(EX_BR_TYPE);

  branch_cond_gen u_cond (
    .RS1      (RS1),
    .RS2      (RS2),
    .EX_FUNC3 (EX_FUNC3),
    .cond     (cond)
  );

  // Pick the transfer target; JALR clears bit 0 as the ISA requires.
  always_comb begin
    target = BRANCH;
    case (br_type)
      BR_JAL:  target = JAL;
      BR_JALR: target = JALR & ~32'h0000_0001;
      default: target = BRANCH;
    endcase
  end

  // Resolve the EX transfer; a misaligned target is reported but never followed.
  always_comb begin
    in_seq     = (state == ST_SEQ);
    taken      = 1'b0;
    if (EX_VALID && in_seq) begin
      case (br_type)
        BR_JAL, BR_JALR: taken = 1'b1;
        BR_BRANCH:       taken = cond;
        default:         taken = 1'b0;
      endcase
    end
    misaligned = taken & target[1];
    redirect   = taken & ~target[1];
  end

  // Outputs are forced low while reset is held so nothing leaks out of EX.
  assign BR_TAKEN         = RST_N & taken;
  assign MISALIGN         = RST_N & misaligned;
  assign FLUSH            = RST_N & (redirect | (state == ST_REDIR_WAIT));
  assign FETCH_VALID      = RST_N & in_seq & ~taken & ~STALL & IMEM_READY;
  assign REDIRECT_PENDING = (state == ST_REDIR_WAIT);
  assign PC_OUT           = pc_q;
  assign PC_PLUS4         = pc_q + 32'd4;

  // PC/state sequencer: redirect beats stall, a busy memory parks the target.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_SEQ;
      pc_q      <= RESET_VECTOR;
      pending_q <= 32'h0000_0000;
    end else begin
      case (state)
        ST_SEQ: begin
          if (redirect) begin
            if (IMEM_READY) begin
              pc_q <= target;
            end else begin
              pending_q <= target;
              state     <= ST_REDIR_WAIT;
            end
          end else if (!STALL && IMEM_READY) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        ST_REDIR_WAIT: begin
          if (IMEM_READY) begin
            pc_q  <= pending_q;
            state <= ST_SEQ;
          end
        end
        default: state <= ST_SEQ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - randomized and directed self-checking bench for pc_redirect_unit
module tb_pc_redirect_unit;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        EX_VALID;
  logic [1:0]  EX_BR_TYPE;
  logic [2:0]  EX_FUNC3;
  logic [31:0] RS1, RS2, JAL, JALR, BRANCH;
  logic        STALL, IMEM_READY;
  logic [31:0] PC_OUT, PC_PLUS4;
  logic        FETCH_VALID, BR_TAKEN, FLUSH, REDIRECT_PENDING, MISALIGN;

  int checks = 0;
  int failures = 0;

  pc_redirect_unit #(.RESET_VECTOR(RV)) dut (
    .CLK(CLK), .RST_N(RST_N), .EX_VALID(EX_VALID), .EX_BR_TYPE(EX_BR_TYPE),
    .EX_FUNC3(EX_FUNC3), .RS1(RS1), .RS2(RS2), .JAL(JAL), .JALR(JALR),
    .BRANCH(BRANCH), .STALL(STALL), .IMEM_READY(IMEM_READY), .PC_OUT(PC_OUT),
    .PC_PLUS4(PC_PLUS4), .FETCH_VALID(FETCH_VALID), .BR_TAKEN(BR_TAKEN),
    .FLUSH(FLUSH), .REDIRECT_PENDING(REDIRECT_PENDING), .MISALIGN(MISALIGN)
  );

  always #5 CLK = ~CLK;

  // Reference model: the fetch PC, whether a redirect is parked, and its target.
  logic [31:0] m_pc, m_pend, n_pc, n_pend;
  bit          m_wait, n_wait;
  bit          model_on = 0;

  function automatic bit cond_ok(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on the falling edge and prepare the next model state.
  always @(negedge CLK) begin
    if (model_on) begin
      bit e_tk, e_mis, e_red, e_fl, e_fv;
      logic [31:0] tgt;
      if (!RST_N) begin
        chk("rst_pc", PC_OUT, RV);
        chk("rst_flags", {BR_TAKEN, FLUSH, FETCH_VALID, REDIRECT_PENDING, MISALIGN}, 0);
        n_pc = RV; n_pend = 0; n_wait = 0;
      end else begin
        tgt = (EX_BR_TYPE == 2) ? JAL : (EX_BR_TYPE == 3) ? {JALR[31:1], 1'b0} : BRANCH;
        e_tk  = EX_VALID && !m_wait &&
                (EX_BR_TYPE >= 2 || (EX_BR_TYPE == 1 && cond_ok(EX_FUNC3, RS1, RS2)));
        e_mis = e_tk && tgt[1];
        e_red = e_tk && !tgt[1];
        e_fl  = e_red || m_wait;
        e_fv  = !m_wait && !e_tk && !STALL && IMEM_READY;
        chk("pc_out", PC_OUT, m_pc);
        chk("pc_plus4", PC_PLUS4, m_pc + 32'd4);
        chk("br_taken", BR_TAKEN, e_tk);
        chk("misalign", MISALIGN, e_mis);
        chk("flush", FLUSH, e_fl);
        chk("fetch_valid", FETCH_VALID, e_fv);
        chk("redirect_pending", REDIRECT_PENDING, m_wait);
        n_pc = m_pc; n_pend = m_pend; n_wait = m_wait;
        if (m_wait) begin
          if (IMEM_READY) begin n_pc = m_pend; n_wait = 0; end
        end else if (e_red) begin
          if (IMEM_READY) n_pc = tgt;
          else begin n_pend = tgt; n_wait = 1; end
        end else if (!STALL && IMEM_READY) begin
          n_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Commit the model on the rising edge; a held reset wins.
  always @(posedge CLK) begin
    if (!RST_N) begin
      m_pc <= RV; m_pend <= 0; m_wait <= 0; model_on <= 1;
    end else if (model_on) begin
      m_pc <= n_pc; m_pend <= n_pend; m_wait <= n_wait;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    EX_VALID = 0; EX_BR_TYPE = 0; EX_FUNC3 = 0; RS1 = 0; RS2 = 0;
    JAL = 0; JALR = 0; BRANCH = 0; STALL = 0; IMEM_READY = 1;
  endtask

  task automatic xfer(input logic [1:0] ty, input logic [31:0] tgt, input logic rdy);
    EX_VALID = 1; EX_BR_TYPE = ty; IMEM_READY = rdy;
    JAL = tgt; JALR = tgt; BRANCH = tgt;
  endtask

  initial begin
    idle();
    RST_N = 0;
    EX_VALID = 1; EX_BR_TYPE = 2; JAL = 32'h80;
    tick(); tick();
    #1;
    chk("lit_reset_pc", PC_OUT, 32'h0);
    chk("lit_reset_taken", BR_TAKEN, 0);
    chk("lit_reset_fv", FETCH_VALID, 0);
    tick();
    // Sequential fetch from the reset vector.
    idle(); RST_N = 1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("lit_seq_pc", PC_OUT, 32'(i * 4));
      chk("lit_seq_fv", FETCH_VALID, 1);
      tick();
    end
    // Signed BLT taken, then unsigned LTU with the same operands not taken.
    xfer(1, 32'h40, 1); EX_FUNC3 = 3'b100; RS1 = 32'hFFFF_FFFF; RS2 = 1; #1;
    chk("lit_blt_taken", BR_TAKEN, 1);
    chk("lit_blt_flush", FLUSH, 1);
    tick();
    chk("lit_blt_pc", PC_OUT, 32'h40);
    EX_FUNC3 = 3'b110; #1;
    chk("lit_bltu_taken", BR_TAKEN, 0);
    tick(); EX_VALID = 0;
    chk("lit_bltu_pc", PC_OUT, 32'h44);
    // JALR to a misaligned target is rejected.
    xfer(3, 32'h103, 0); #1;
    chk("lit_jalr_mis", MISALIGN, 1);
    chk("lit_jalr_mis_flush", FLUSH, 0);
    tick(); EX_VALID = 0; #1;
    chk("lit_jalr_mis_pend", REDIRECT_PENDING, 0);
    chk("lit_jalr_mis_pc", PC_OUT, 32'h44);
    // JALR parked while memory is busy for two cycles.
    xfer(3, 32'h101, 0); #1;
    chk("lit_jalr_flush", FLUSH, 1);
    tick(); #1;
    chk("lit_wait_pend", REDIRECT_PENDING, 1);
    chk("lit_wait_taken", BR_TAKEN, 0);
    tick(); IMEM_READY = 1; #1;
    chk("lit_wait_flush", FLUSH, 1);
    tick(); EX_VALID = 0; #1;
    chk("lit_jalr_pc", PC_OUT, 32'h100);
    // Redirect beats stall; stall alone holds.
    xfer(2, 32'h200, 1); STALL = 1; #1;
    chk("lit_stall_jal_taken", BR_TAKEN, 1);
    tick(); EX_VALID = 0;
    chk("lit_stall_jal_pc", PC_OUT, 32'h200);
    chk("lit_stall_fv", FETCH_VALID, 0);
    tick();
    chk("lit_stall_hold", PC_OUT, 32'h200);
    // Reset in the middle of a parked redirect.
    STALL = 0; xfer(2, 32'h300, 0);
    tick(); EX_VALID = 0; #1;
    chk("lit_pre_rst_pend", REDIRECT_PENDING, 1);
    RST_N = 0; #1;
    chk("lit_mid_rst_pc", PC_OUT, RV);
    chk("lit_mid_rst_pend", REDIRECT_PENDING, 0);
    tick();
    RST_N = 1; IMEM_READY = 1; #1;
    chk("lit_post_rst_pc", PC_OUT, RV);
    chk("lit_post_rst_fv", FETCH_VALID, 1);
    // Wrap at the top of the address space.
    xfer(2, 32'hFFFF_FFFC, 1);
    tick(); EX_VALID = 0; #1;
    chk("lit_wrap_plus4", PC_PLUS4, 32'h0);
    tick();
    chk("lit_wrap_pc", PC_OUT, 32'h0);
    // Randomized traffic checked by the model.
    for (int c = 0; c < 3000; c++) begin
      EX_VALID   = ($urandom_range(0, 2) != 0);
      EX_BR_TYPE = 2'($urandom_range(0, 3));
      EX_FUNC3   = 3'($urandom_range(0, 7));
      RS1        = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 3)) - 32'd2;
      RS2        = ($urandom_range(0, 3) == 0) ? RS1 : (($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 3)) - 32'd2);
      JAL        = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
      JALR       = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
      BRANCH     = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
      STALL      = ($urandom_range(0, 3) == 0);
      IMEM_READY = ($urandom_range(0, 9) < 6);
      RST_N      = ($urandom_range(0, 199) != 0);
      tick();
    end
    RST_N = 1; idle();
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
